oki_bank_mapper: RTL and testbench

Parametrised, clocked successor to the NMK-112 OKI sample-ROM bank switcher. Decodes CPU writes into per-channel, per-page bank registers and drives a registered bank address for each OKI channel from that channel's upper address lines, with sample-table detection. Sits between the sound-CPU bus and up to 8 OKI M6295 channels. Bus strobes are synchronised into the system clock, and bank changes can optionally be deferred to sample boundaries.

---
 rtl/oki_bank_mapper.sv | 156 +++++++++++++++
 tb/tb_oki_bank_mapper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/oki_bank_mapper.sv
// oki_bank_mapper: clocked NMK-112 style OKI sample-ROM bank switcher for up to 8 channels.
// Build macro OKI_BANK_DEFER_EN: bank changes apply only at sample-table fetches.

module oki_bank_lane #(
   parameter int BANK_W = 6
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              wr_en,
   input  logic [1:0]        wr_pg,
   input  logic [BANK_W-1:0] wr_data,
   input  logic [9:0]        oki_a,
   output logic [BANK_W-1:0] bank_out
);
   logic [3:0][BANK_W-1:0] bank;
   logic [3:0][BANK_W-1:0] active;
   logic                   table_hit;
   logic [1:0]             page;

   // oki_a holds OKI address bits 17:8; the sample table lives where bits 17:10 are zero
   assign table_hit = (oki_a[9:2] == 8'd0);
   assign page      = table_hit ? oki_a[1:0] : oki_a[9:8];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         bank <= '0;
      else if (wr_en)
         bank[wr_pg] <= wr_data;
   end

`ifdef OKI_BANK_DEFER_EN
   // a table fetch marks a new sample, so the shadow banks go live only then
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         active <= '0;
      else if (table_hit)
         active <= bank;
   end
`else
   assign active = bank;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         bank_out <= '0;
      else
         bank_out <= active[page];
   end
endmodule

module oki_bank_mapper #(
   parameter  int CHANNELS = 2,
   parameter  int BANK_W   = 6,
   localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW       = CH_BITS + 3
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       nCS,
   input  logic                       nWR,
   input  logic [AW-1:0]              A,
   input  logic [BANK_W-1:0]          D,
   input  logic [CHANNELS*10-1:0]     OKI_A,
   output logic [CHANNELS-1:0]        nOKI_SEL,
   output logic [CHANNELS*BANK_W-1:0] OKI_BANK
);
   localparam int SYNC_STAGES = 2;

   typedef struct packed {
      logic              ncs;
      logic              nwr;
      logic [AW-1:0]     a;
      logic [BANK_W-1:0] d;
   } bus_t;

   typedef struct packed {
      logic [CH_BITS-1:0] ch;
      logic [1:0]         pg;
      logic [BANK_W-1:0]  d;
   } hold_t;

   bus_t                   bus_s1, bus_s2;
   hold_t                  hold;
   logic [SYNC_STAGES-1:0] vld_pipe;
   logic                   armed;
   logic                   strobe_s2;
   logic                   wr;
   logic                   wr_s3;
   logic                   hold_vld;
   logic                   commit;

   genvar n;
   generate
      for (n = 0; n < CHANNELS; n++) begin : g_sel
         assign nOKI_SEL[n] = !(!nCS && !A[AW-1] && (A[AW-2:2] == CH_BITS'(n)));
      end
   endgenerate

   assign strobe_s2 = !bus_s2.ncs && !bus_s2.nwr && bus_s2.a[AW-1];
   assign wr        = strobe_s2 && armed;
   assign commit    = wr_s3 && !wr && hold_vld;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bus_s1 <= '0;
         bus_s2 <= '0;
      end else begin
         bus_s1 <= '{ncs: nCS, nwr: nWR, a: A, d: D};
         bus_s2 <= bus_s1;
      end
   end

   // A strobe already low when reset releases is ignored: accept writes only after
   // a real (post-reset) idle sample has reached s2.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         vld_pipe <= '0;
         armed    <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
         if (vld_pipe[SYNC_STAGES-1] && !strobe_s2)
            armed <= 1'b1;
      end
   end

   // hold_vld needs two consecutive strobe samples, so single-edge glitches never commit
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_s3    <= 1'b0;
         hold_vld <= 1'b0;
         hold     <= '0;
      end else begin
         wr_s3 <= wr;
         if (wr)
            hold <= '{ch: bus_s2.a[AW-2:2], pg: bus_s2.a[1:0], d: bus_s2.d};
         if (wr && wr_s3)
            hold_vld <= 1'b1;
         else if (!wr)
            hold_vld <= 1'b0;
      end
   end

   generate
      for (n = 0; n < CHANNELS; n++) begin : g_lane
         oki_bank_lane #(.BANK_W(BANK_W)) u_lane (
            .CLK      (CLK),
            .nRST     (nRST),
            .wr_en    (commit && (hold.ch == CH_BITS'(n))),
            .wr_pg    (hold.pg),
            .wr_data  (hold.d),
            .oki_a    (OKI_A[n*10 +: 10]),
            .bank_out (OKI_BANK[n*BANK_W +: BANK_W])
         );
      end
   endgenerate
endmodule

// File: tb/tb_oki_bank_mapper.sv
// Scoreboard bench for oki_bank_mapper (3 channels, 6-bit banks); stimulus queues
// expectations with a due cycle, a monitor compares them against the outputs.

module tb_oki_bank_mapper;
   localparam int CH = 3;
   localparam int BW = 6;
   localparam int AW = 5;

   logic             CLK = 1'b0;
   logic             nRST, nCS, nWR;
   logic [AW-1:0]    A;
   logic [BW-1:0]    D;
   logic [CH*10-1:0] OKI_A;
   logic [CH-1:0]    nOKI_SEL;
   logic [CH*BW-1:0] OKI_BANK;

   typedef struct {
      int         due;
      int         kind;
      int         idx;
      logic [7:0] exp;
      string      name;
   } chk_t;

   chk_t q[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   oki_bank_mapper #(.CHANNELS(CH), .BANK_W(BW)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .nCS      (nCS),
      .nWR      (nWR),
      .A        (A),
      .D        (D),
      .OKI_A    (OKI_A),
      .nOKI_SEL (nOKI_SEL),
      .OKI_BANK (OKI_BANK)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].due == cyc) begin
            logic [7:0] act;
            act = (q[i].kind == 0) ? 8'(OKI_BANK[q[i].idx*BW +: BW]) : 8'(nOKI_SEL);
            checks++;
            if (act !== q[i].exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h (cycle %0d)", q[i].name, act, q[i].exp, cyc);
            end
            q.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic expect_bank(input int ch, input int due, input logic [7:0] e, input string nm);
      chk_t c;
      c.due = due; c.kind = 0; c.idx = ch; c.exp = e; c.name = nm;
      q.push_back(c);
   endtask

   task automatic expect_sel(input logic [7:0] e, input string nm);
      chk_t c;
      c.due = cyc; c.kind = 1; c.idx = 0; c.exp = e; c.name = nm;
      q.push_back(c);
   endtask

   task automatic set_oki(input int ch, input logic [9:0] v);
      OKI_A[ch*10 +: 10] = v;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input int low,
                            output int rel);
      A = a; D = d; nCS = 1'b0; nWR = 1'b0;
      tick(low);
      nCS = 1'b1; nWR = 1'b1;
      rel = cyc;
   endtask

   initial begin
      int rel;
      int k;
      nRST = 1'b0; nCS = 1'b1; nWR = 1'b1; A = '0; D = '0;
      OKI_A = {10'h2AB, 10'h1F3, 10'h0C5};
      tick(2);
      for (int c = 0; c < CH; c++) expect_bank(c, cyc, 8'h00, "reset_bank");
      expect_sel(8'h07, "reset_sel");
      tick(1);
      nRST = 1'b1;
      tick(4);

      // chip-select decode straight from the pins
      nCS = 1'b0;
      A = 5'b0_01_00; expect_sel(8'h05, "sel_ch1");      tick(1);
      A = 5'b0_10_11; expect_sel(8'h03, "sel_ch2");      tick(1);
      A = 5'b0_11_00; expect_sel(8'h07, "sel_ch3_none"); tick(1);
      A = 5'b1_01_00; expect_sel(8'h07, "sel_regspace"); tick(1);
      nCS = 1'b1; A = '0;
      tick(4);

`ifdef OKI_BANK_DEFER_EN
      set_oki(0, 10'h100); set_oki(1, 10'h000); set_oki(2, 10'h000);
      tick(2);
      bus_write(5'b1_00_00, 6'h07, 2, rel);
      expect_bank(0, rel + 4, 8'h00, "defer_hold_mid_sample");
      expect_bank(0, rel + 6, 8'h00, "defer_hold_late");
      tick(8);
      set_oki(0, 10'h000);
      k = cyc;
      expect_bank(0, k + 1, 8'h00, "defer_copy_edge");
      expect_bank(0, k + 2, 8'h07, "defer_applied");
      tick(4);
`else
      set_oki(0, 10'h000); set_oki(1, 10'h200); set_oki(2, 10'h000);
      tick(2);
      bus_write(5'b1_01_10, 6'h2A, 3, rel);
      expect_bank(1, rel + 3, 8'h00, "ch1_before_latency");
      expect_bank(1, rel + 4, 8'h2A, "ch1_pg2_write");
      expect_bank(0, rel + 4, 8'h00, "ch0_untouched");
      tick(6);

      bus_write(5'b1_00_11, 6'h15, 2, rel);
      tick(6);
      set_oki(0, 10'h003);
      k = cyc;
      expect_bank(0, k,     8'h00, "ch0_lookup_old_addr");
      expect_bank(0, k + 1, 8'h15, "ch0_table_pg3");
      tick(2);
      set_oki(0, 10'h3C3); expect_bank(0, cyc + 1, 8'h15, "ch0_high_pg3");     tick(2);
      set_oki(0, 10'h0C3); expect_bank(0, cyc + 1, 8'h00, "ch0_nontable_pg0"); tick(2);

      set_oki(2, 10'h001);
      tick(2);
      bus_write(5'b1_10_01, 6'h11, 2, rel);
      expect_bank(2, rel + 3, 8'h00, "ch2_before_latency");
      expect_bank(2, rel + 4, 8'h11, "ch2_table_pg1");
      tick(6);

      // single-edge strobe must be dropped
      set_oki(0, 10'h000);
      tick(2);
      bus_write(5'b1_00_00, 6'h3F, 1, rel);
      expect_bank(0, rel + 6, 8'h00, "short_strobe_dropped");
      tick(8);

      // channel 3 does not exist; nothing may change
      set_oki(1, 10'h000); set_oki(2, 10'h000);
      tick(2);
      bus_write(5'b1_11_00, 6'h3F, 3, rel);
      expect_bank(0, rel + 5, 8'h00, "ch_oob_ch0");
      expect_bank(1, rel + 5, 8'h00, "ch_oob_ch1");
      expect_bank(2, rel + 5, 8'h00, "ch_oob_ch2");
      tick(6);
      set_oki(1, 10'h200); set_oki(2, 10'h001);
      expect_bank(1, cyc + 1, 8'h2A, "ch1_retained");
      expect_bank(2, cyc + 1, 8'h11, "ch2_retained");
      tick(2);

      // reset in the middle of a strobe that outlasts the reset pulse
      set_oki(0, 10'h001);
      tick(1);
      A = 5'b1_00_01; D = 6'h3F; nCS = 1'b0; nWR = 1'b0;
      tick(2);
      nRST = 1'b0;
      expect_bank(1, cyc, 8'h00, "rst_clears_ch1");
      expect_bank(2, cyc, 8'h00, "rst_clears_ch2");
      tick(1);
      nRST = 1'b1;
      tick(2);
      nCS = 1'b1; nWR = 1'b1;
      rel = cyc;
      expect_bank(0, rel + 5, 8'h00, "rst_strobe_dropped");
      tick(8);

      bus_write(5'b1_00_01, 6'h21, 2, rel);
      expect_bank(0, rel + 4, 8'h21, "post_reset_write");
      tick(6);
`endif

      for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
